// File: rtl/mips_io_pkg.sv
// Shared IO map constants and register-select encoding for the MIPS IO bridge.
package mips_io_pkg;

    localparam logic [7:0] IO_STATUS = 8'h80;
    localparam logic [7:0] IO_LED    = 8'h84;
    localparam logic [7:0] IO_SW     = 8'h88;
    localparam logic [7:0] IO_SEG    = 8'h8C;

    localparam int ST_IN_RDY  = 0;
    localparam int ST_OUT_RDY = 1;

    typedef enum logic [1:0] {
        REG_STATUS = IO_STATUS[3:2],
        REG_LED    = IO_LED[3:2],
        REG_SW     = IO_SW[3:2],
        REG_SEG    = IO_SEG[3:2]
    } io_reg_e;

    function automatic io_reg_e io_sel(input logic [31:0] a);
        return io_reg_e'(a[3:2]);
    endfunction

endpackage

// File: rtl/hex7seg.sv
// Hex nibble to active-low 7-segment pattern, bit 0 = segment a, bit 6 = g.
module hex7seg (
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = 7'h7F;
        unique case (i_hex)
            4'h0: o_seg = 7'b1000000;
            4'h1: o_seg = 7'b1111001;
            4'h2: o_seg = 7'b0100100;
            4'h3: o_seg = 7'b0110000;
            4'h4: o_seg = 7'b0011001;
            4'h5: o_seg = 7'b0010010;
            4'h6: o_seg = 7'b0000010;
            4'h7: o_seg = 7'b1111000;
            4'h8: o_seg = 7'b0000000;
            4'h9: o_seg = 7'b0010000;
            4'hA: o_seg = 7'b0001000;
            4'hB: o_seg = 7'b0000011;
            4'hC: o_seg = 7'b1000110;
            4'hD: o_seg = 7'b0100001;
            4'hE: o_seg = 7'b0000110;
            4'hF: o_seg = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/io_bridge_btn.sv
// Button synchronizer, optional debounce (IO_DEBOUNCE_EN) and rising-edge detect.
module io_bridge_btn #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_rise
);

    logic [1:0] r_sync;
    logic [1:0] r_vld;
    logic       r_prev;
    logic       r_armed;
    logic       w_level;
    logic       w_quiet;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= 2'b00;
            r_vld  <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], i_btn};
            r_vld  <= {r_vld[0], 1'b1};
        end
    end

`ifdef IO_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_stable;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_stable <= 1'b0;
        end else if (!r_vld[1] || r_sync[1] == r_stable) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_stable <= r_sync[1];
            r_cnt    <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_level = r_stable;
    assign w_quiet = r_vld[1] & ~r_sync[1] & ~r_stable;
`else
    assign w_level = r_sync[1] & r_vld[1];
    assign w_quiet = r_vld[1] & ~r_sync[1];
`endif

    // Edges only count once a genuine released level has been seen after reset
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_prev <= w_level;
            if (w_quiet) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign o_rise = w_level & ~r_prev & r_armed;

endmodule

// File: rtl/io_bridge.sv
// Memory-mapped IO bridge: LEDs, latched switches, button ready flags, 8-digit 7-seg scan.
// Define IO_DEBOUNCE_EN to debounce both buttons over DEBOUNCE_CYCLES samples.
module io_bridge
    import mips_io_pkg::*;
#(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    input  logic        memwrite,
    output logic [31:0] readdata,
    output logic        dmem_we,
    input  logic [31:0] dmem_rd,
    input  logic [15:0] sw,
    input  logic        btnl,
    input  logic        btnr,
    output logic [11:0] led,
    output logic [7:0]  an,
    output logic [6:0]  seg
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [11:0]   r_led;
    logic [31:0]   r_seg_val;
    logic [15:0]   r_sw_s1;
    logic [15:0]   r_sw_s2;
    logic [15:0]   r_sw_lat;
    logic          r_in_rdy;
    logic          r_out_rdy;
    logic [DW-1:0] r_div;
    logic [2:0]    r_idx;
    logic [7:0]    r_an;
    logic [6:0]    r_seg;

    io_reg_e       w_sel;
    logic          w_io_wr;
    logic          w_clr;
    logic          w_rise_r;
    logic          w_rise_l;
    logic [3:0]    w_nib;
    logic [6:0]    w_pat;
    logic          w_unused;

    assign w_sel    = io_sel(adr);
    assign w_io_wr  = memwrite & adr[7] & (adr[6:4] == 3'b000);
    assign w_clr    = w_io_wr & (w_sel == REG_STATUS);
    assign dmem_we  = memwrite & ~adr[7];
    assign w_unused = ^{adr[31:8], adr[1:0]};

    io_bridge_btn #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_r (
        .clk   (clk),
        .reset (reset),
        .i_btn (btnr),
        .o_rise(w_rise_r)
    );

    io_bridge_btn #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_l (
        .clk   (clk),
        .reset (reset),
        .i_btn (btnl),
        .o_rise(w_rise_l)
    );

    always_comb begin
        readdata = dmem_rd;
        if (adr[7]) begin
            unique case (w_sel)
                REG_STATUS: readdata = {30'b0, r_out_rdy, r_in_rdy};
                REG_SW:     readdata = {16'b0, r_sw_lat};
                default:    readdata = 32'b0;
            endcase
        end
    end

    // A set event in the same cycle as a clear leaves the flag set
    always_ff @(posedge clk) begin
        if (reset) begin
            r_led     <= '0;
            r_seg_val <= '0;
            r_sw_s1   <= '0;
            r_sw_s2   <= '0;
            r_sw_lat  <= '0;
            r_in_rdy  <= 1'b0;
            r_out_rdy <= 1'b0;
        end else begin
            r_sw_s1 <= sw;
            r_sw_s2 <= r_sw_s1;
            if (w_rise_r) begin
                r_sw_lat <= r_sw_s2;
            end
            if (w_io_wr && w_sel == REG_LED) begin
                r_led <= writedata[11:0];
            end
            if (w_io_wr && w_sel == REG_SEG) begin
                r_seg_val <= writedata;
            end
            r_in_rdy  <= w_rise_r |
                         (r_in_rdy & ~(w_clr & writedata[ST_IN_RDY]));
            r_out_rdy <= w_rise_l |
                         (r_out_rdy & ~(w_clr & writedata[ST_OUT_RDY]));
        end
    end

    assign w_nib = r_seg_val[{r_idx, 2'b00} +: 4];

    hex7seg u_hex (
        .i_hex(w_nib),
        .o_seg(w_pat)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= '0;
            r_idx <= 3'd0;
            r_an  <= 8'hFE;
            r_seg <= 7'b1000000;
        end else begin
            if (r_div == DIV_LAST) begin
                r_div <= '0;
                r_idx <= r_idx + 3'd1;
            end else begin
                r_div <= r_div + 1'b1;
            end
            r_an  <= ~(8'd1 << r_idx);
            r_seg <= w_pat;
        end
    end

    assign led = r_led;
    assign an  = r_an;
    assign seg = r_seg;

endmodule

// File: tb/tb_io_bridge.sv
// Self-checking bench for io_bridge: vector table, random MMIO traffic vs. a model,
// and hand sequences for buttons, scan and reset corner cases.
module tb_io_bridge;

    localparam int SD = 4;
    localparam int DB = 8;
`ifdef IO_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
    localparam logic GLITCH_SETS = 1'b0;
`else
    localparam int LAT = 2;
    localparam logic GLITCH_SETS = 1'b1;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] adr;
    logic [31:0] writedata;
    logic        memwrite;
    logic [31:0] readdata;
    logic        dmem_we;
    logic [31:0] dmem_rd;
    logic [15:0] sw;
    logic        btnl;
    logic        btnr;
    logic [11:0] led;
    logic [7:0]  an;
    logic [6:0]  seg;

    io_bridge #(
        .SCAN_DIV       (SD),
        .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .adr      (adr),
        .writedata(writedata),
        .memwrite (memwrite),
        .readdata (readdata),
        .dmem_we  (dmem_we),
        .dmem_rd  (dmem_rd),
        .sw       (sw),
        .btnl     (btnl),
        .btnr     (btnr),
        .led      (led),
        .an       (an),
        .seg      (seg)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] wd;
        logic        we;
        logic [31:0] drd;
        logic        exp_we;
        logic [31:0] exp_rd;
        logic [11:0] exp_led;
    } vec_t;

    vec_t tv[8];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        adr       = a;
        writedata = d;
        memwrite  = 1'b1;
        step();
        memwrite  = 1'b0;
        #1;
    endtask

    task automatic rd_chk(input string nm, input logic [31:0] a,
                          input logic [31:0] exp);
        adr = a;
        #1;
        chk(nm, readdata, exp);
    endtask

    function automatic logic [6:0] pat(input logic [3:0] h);
        case (h)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h08;
            4'hB: return 7'h03;
            4'hC: return 7'h46;
            4'hD: return 7'h21;
            4'hE: return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    initial begin
        logic [11:0] m_led;
        logic        m_in;
        logic        m_out;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] seg_word;
        logic [31:0] exp_rd;
        logic        we;
        logic        ok;
        int          kind;

        reset     = 1'b1;
        adr       = 32'h0;
        writedata = 32'h0;
        memwrite  = 1'b0;
        dmem_rd   = 32'h0;
        sw        = 16'h0;
        btnl      = 1'b0;
        btnr      = 1'b0;
        steps(3);
        chk("rst_led", {20'b0, led}, 32'h0);
        chk("rst_an", {24'b0, an}, 32'hFE);
        chk("rst_seg", {25'b0, seg}, 32'h40);
        rd_chk("rst_status", 32'h80, 32'h0);
        rd_chk("rst_sw", 32'h88, 32'h0);
        reset = 1'b0;
        steps(4);

        tv[0] = '{32'h10, 32'h1234, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 12'h000};
        tv[1] = '{32'h84, 32'h1234, 1'b1, 32'h11111111, 1'b0, 32'h0, 12'h234};
        tv[2] = '{32'h94, 32'hFFFFF999, 1'b1, 32'h22222222, 1'b0, 32'h0, 12'h234};
        tv[3] = '{32'h88, 32'h00000ABC, 1'b1, 32'h33333333, 1'b0, 32'h0, 12'h234};
        tv[4] = '{32'h8C, 32'h0, 1'b0, 32'h44444444, 1'b0, 32'h0, 12'h234};
        tv[5] = '{32'hFFFFFF7C, 32'h5555, 1'b1, 32'h0BADF00D, 1'b1, 32'h0BADF00D, 12'h234};
        tv[6] = '{32'h80, 32'h3, 1'b0, 32'h55555555, 1'b0, 32'h0, 12'h234};
        tv[7] = '{32'h01000084, 32'hABC, 1'b1, 32'h66666666, 1'b0, 32'h0, 12'hABC};

        for (int i = 0; i < 8; i++) begin
            adr       = tv[i].adr;
            writedata = tv[i].wd;
            memwrite  = tv[i].we;
            dmem_rd   = tv[i].drd;
            #1;
            chk($sformatf("tv%0d_we", i), {31'b0, dmem_we}, {31'b0, tv[i].exp_we});
            chk($sformatf("tv%0d_rd", i), readdata, tv[i].exp_rd);
            step();
            memwrite = 1'b0;
            #1;
            chk($sformatf("tv%0d_led", i), {20'b0, led}, {20'b0, tv[i].exp_led});
        end

        m_led = 12'hABC;
        m_in  = 1'b0;
        m_out = 1'b0;
        for (int i = 0; i < 150; i++) begin
            kind = $urandom_range(0, 3);
            a    = $urandom;
            d    = $urandom;
            we   = 1'($urandom_range(0, 1));
            if (kind == 0) begin
                a = a & ~32'h80;
            end else if (kind == 2) begin
                a = (a & ~32'hFC) | 32'h80 | (32'($urandom_range(0, 3)) << 2)
                    | (32'($urandom_range(1, 7)) << 4);
            end else begin
                a = (a & ~32'hFC) | 32'h80 | (32'($urandom_range(0, 3)) << 2);
            end
            adr       = a;
            writedata = d;
            memwrite  = we;
            dmem_rd   = $urandom;
            #1;
            if (!a[7]) exp_rd = dmem_rd;
            else if (a[3:2] == 2'd0) exp_rd = {30'b0, m_out, m_in};
            else exp_rd = 32'h0;
            chk("rnd_we", {31'b0, dmem_we}, {31'b0, we & ~a[7]});
            chk("rnd_rd", readdata, exp_rd);
            step();
            memwrite = 1'b0;
            if (we && a[7] && a[6:4] == 3'b0) begin
                if (a[3:2] == 2'd0) begin
                    if (d[0]) m_in = 1'b0;
                    if (d[1]) m_out = 1'b0;
                end else if (a[3:2] == 2'd1) begin
                    m_led = d[11:0];
                end
            end
            #1;
            chk("rnd_led", {20'b0, led}, {20'b0, m_led});
        end

        sw   = 16'hBEEF;
        btnr = 1'b1;
        steps(20);
        btnr = 1'b0;
        rd_chk("btnr_status", 32'h80, 32'h1);
        rd_chk("btnr_sw", 32'h88, 32'h0000BEEF);
        sw = 16'h1234;
        steps(3);
        rd_chk("sw_held", 32'h88, 32'h0000BEEF);
        store(32'h80, 32'h1);
        rd_chk("in_clr", 32'h80, 32'h0);
        steps(20);

        store(32'h8C, 32'h87654321);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            step();
            if (an == 8'h7F) ok = 1'b1;
        end
        chk("scan_find_7F", {31'b0, ok}, 32'h1);
        ok = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            step();
            if (an == 8'hFE) ok = 1'b1;
        end
        chk("scan_find_FE", {31'b0, ok}, 32'h1);
        seg_word = 32'h87654321;
        for (int c = 0; c < 32; c++) begin
            chk($sformatf("scan_an%0d", c), {24'b0, an},
                {24'b0, ~(8'd1 << (c / 4))});
            chk($sformatf("scan_seg%0d", c), {25'b0, seg},
                {25'b0, pat(4'((seg_word >> (4 * (c / 4))) & 32'hF))});
            step();
        end
        chk("scan_wrap", {24'b0, an}, 32'hFE);

        btnl = 1'b1;
        steps(3);
        btnl = 1'b0;
        steps(15);
        rd_chk("glitch", 32'h80, {30'b0, GLITCH_SETS, 1'b0});
        store(32'h80, 32'h2);
        rd_chk("glitch_clr", 32'h80, 32'h0);
        steps(15);

        btnl = 1'b1;
        steps(LAT);
        adr       = 32'h80;
        writedata = 32'h2;
        memwrite  = 1'b1;
        #1;
        chk("race_pre", readdata, 32'h0);
        step();
        memwrite = 1'b0;
        #1;
        chk("race_set_wins", readdata, 32'h2);
        store(32'h80, 32'h2);
        rd_chk("race_clr", 32'h80, 32'h0);
        btnl = 1'b0;
        steps(20);

        btnr  = 1'b1;
        reset = 1'b1;
        steps(2);
        reset = 1'b0;
        steps(30);
        rd_chk("held_rst", 32'h80, 32'h0);
        btnr = 1'b0;
        steps(20);
        rd_chk("held_rel", 32'h80, 32'h0);
        btnr = 1'b1;
        steps(20);
        btnr = 1'b0;
        rd_chk("held_repress", 32'h80, 32'h1);

        store(32'h84, 32'hFFF);
        chk("mid_led", {20'b0, led}, 32'hFFF);
        ok = 1'b0;
        for (int i = 0; i < 40 && !ok; i++) begin
            step();
            if (an == 8'hFB) ok = 1'b1;
        end
        chk("mid_find", {31'b0, ok}, 32'h1);
        reset = 1'b1;
        step();
        chk("mrst_led", {20'b0, led}, 32'h0);
        chk("mrst_an", {24'b0, an}, 32'hFE);
        chk("mrst_seg", {25'b0, seg}, 32'h40);
        rd_chk("mrst_status", 32'h80, 32'h0);
        rd_chk("mrst_sw", 32'h88, 32'h0);
        reset = 1'b0;
        steps(2);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
